// File: rtl/sc_reggeneral_write_arbiter_pkg.sv
// Shared definitions for the general-register write arbiter: state encoding and default widths.
package sc_reggeneral_write_arbiter_pkg;

  localparam int NUM_REQ_DEF       = 4;
  localparam int REQIDX_WIDTH_DEF  = 2;
  localparam int NUM_REG_DEF       = 6;
  localparam int REGADDR_WIDTH_DEF = 3;
  localparam int DATAWIDTH_BUS_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    ACK   = 2'b10
  } arb_state_t;

endpackage

// File: rtl/sc_reggeneral_write_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NUM_REQ.
module sc_rr_picker
  import sc_reggeneral_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = NUM_REQ_DEF,
  parameter int REQIDX_WIDTH = REQIDX_WIDTH_DEF
) (
  input  logic [NUM_REQ-1:0]      req,
  input  logic [REQIDX_WIDTH-1:0] ptr,
  output logic [REQIDX_WIDTH-1:0] winner,
  output logic                    valid
);

  int                    pos;
  logic [REQIDX_WIDTH-1:0] sel;

  // Scan from the farthest offset down so the nearest requester is the last one assigned.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    pos    = 0;
    sel    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = (int'(ptr) + k) % NUM_REQ;
      sel = REQIDX_WIDTH'(pos);
      if (req[sel]) begin
        winner = sel;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sc_reggeneral_write_arbiter.sv
// Round-robin write arbiter for the general register bank: IDLE -> WRITE -> ACK, all outputs registered.
module sc_reggeneral_write_arbiter
  import sc_reggeneral_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = NUM_REQ_DEF,
  parameter int REQIDX_WIDTH  = REQIDX_WIDTH_DEF,
  parameter int NUM_REG       = NUM_REG_DEF,
  parameter int REGADDR_WIDTH = REGADDR_WIDTH_DEF,
  parameter int DATAWIDTH_BUS = DATAWIDTH_BUS_DEF
) (
  input  logic                               SC_RegWRARB_CLOCK_50,
  input  logic                               SC_RegWRARB_Reset_InLow,
  input  logic [NUM_REQ-1:0]                 SC_RegWRARB_Req_InHigh,
  input  logic [NUM_REQ*REGADDR_WIDTH-1:0]   SC_RegWRARB_Addr_In,
  input  logic [NUM_REQ*DATAWIDTH_BUS-1:0]   SC_RegWRARB_Data_In,
  output logic [NUM_REQ-1:0]                 SC_RegWRARB_Ack_OutHigh,
  output logic [NUM_REG-1:0]                 SC_RegWRARB_Write_OutHigh,
  output logic [DATAWIDTH_BUS-1:0]           SC_RegWRARB_DataBUS_Out,
  output logic                               SC_RegWRARB_Busy_OutHigh,
  output logic                               SC_RegWRARB_Error_OutHigh
);

  arb_state_t              state;
  logic [REQIDX_WIDTH-1:0] ptr;
  logic [REQIDX_WIDTH-1:0] win;
  logic [REQIDX_WIDTH-1:0] pick_idx;
  logic                    pick_vld;

  logic [REGADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [DATAWIDTH_BUS-1:0] data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign addr_arr[i] = SC_RegWRARB_Addr_In[i*REGADDR_WIDTH +: REGADDR_WIDTH];
    assign data_arr[i] = SC_RegWRARB_Data_In[i*DATAWIDTH_BUS +: DATAWIDTH_BUS];
  end

  sc_rr_picker #(
    .NUM_REQ      (NUM_REQ),
    .REQIDX_WIDTH (REQIDX_WIDTH)
  ) u_picker (
    .req    (SC_RegWRARB_Req_InHigh),
    .ptr    (ptr),
    .winner (pick_idx),
    .valid  (pick_vld)
  );

  function automatic logic in_range(input logic [REGADDR_WIDTH-1:0] a);
    return int'(a) < NUM_REG;
  endfunction

  function automatic logic [NUM_REG-1:0] strobe(input logic [REGADDR_WIDTH-1:0] a);
    logic [NUM_REG-1:0] s;
    s = '0;
    if (in_range(a)) s[a] = 1'b1;
    return s;
  endfunction

  // Strobe and error are decided from the winner's address on the grant edge, so they
  // are already registered and stable for the whole WRITE cycle.
  always_ff @(posedge SC_RegWRARB_CLOCK_50 or negedge SC_RegWRARB_Reset_InLow) begin
    if (!SC_RegWRARB_Reset_InLow) begin
      state                     <= IDLE;
      ptr                       <= '0;
      win                       <= '0;
      SC_RegWRARB_Ack_OutHigh   <= '0;
      SC_RegWRARB_Write_OutHigh <= '0;
      SC_RegWRARB_DataBUS_Out   <= '0;
      SC_RegWRARB_Busy_OutHigh  <= 1'b0;
      SC_RegWRARB_Error_OutHigh <= 1'b0;
    end else begin
      SC_RegWRARB_Ack_OutHigh   <= '0;
      SC_RegWRARB_Write_OutHigh <= '0;
      SC_RegWRARB_Error_OutHigh <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            win                       <= pick_idx;
            SC_RegWRARB_DataBUS_Out   <= data_arr[pick_idx];
            SC_RegWRARB_Write_OutHigh <= strobe(addr_arr[pick_idx]);
            SC_RegWRARB_Error_OutHigh <= !in_range(addr_arr[pick_idx]);
            SC_RegWRARB_Busy_OutHigh  <= 1'b1;
            state                     <= WRITE;
          end
        end
        WRITE: begin
          SC_RegWRARB_Ack_OutHigh <= NUM_REQ'(1) << win;
          state                   <= ACK;
        end
        ACK: begin
          ptr                      <= (win == REQIDX_WIDTH'(NUM_REQ - 1)) ? '0 : win + 1'b1;
          SC_RegWRARB_Busy_OutHigh <= 1'b0;
          state                    <= IDLE;
        end
        default: begin
          SC_RegWRARB_Busy_OutHigh <= 1'b0;
          state                    <= IDLE;
        end
      endcase
    end
  end

endmodule
